adaptive_traffic_controller: RTL and testbench

ADAPTIVE_TRAFFIC_CONTROLLER -- requirements
Module: adaptive_traffic_controller

---
 rtl/adaptive_traffic_controller.sv | 161 ++++++++++++++++
 tb/tb_adaptive_traffic_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/adaptive_traffic_controller.sv
// Highway/local-road intersection controller with flash mode.
// Ports: clk, rst (sync, active-high), lr_has_car, flash_mode, ped_req
//        in; hw_light, lr_light {g,y,r}, ped_walk, state (debug) out.
// Optional macro PED_REQ_EN builds the pedestrian request latch.
module adaptive_traffic_controller #(
  parameter int HW_MIN_GREEN = 70,
  parameter int LR_GREEN     = 70,
  parameter int YELLOW       = 25,
  parameter int ALL_RED      = 1,
  parameter int FLASH_HALF   = 10,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lr_has_car,
  input  logic       flash_mode,
  input  logic       ped_req,
  output logic [2:0] hw_light,
  output logic [2:0] lr_light,
  output logic       ped_walk,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    HW_GREEN   = 3'd0,
    HW_YELLOW  = 3'd1,
    CLR_A      = 3'd2,
    LR_GREEN_S = 3'd3,
    LR_YELLOW  = 3'd4,
    CLR_B      = 3'd5,
    FLASH      = 3'd6,
    ST_BAD     = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] T_HWG =
    CNT_W'(HW_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] T_LRG =
    CNT_W'(LR_GREEN - 1);
  localparam logic [CNT_W-1:0] T_YEL =
    CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] T_CLR =
    CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] T_FLS =
    CNT_W'(FLASH_HALF - 1);

  state_t           st;
  state_t           st_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] fcnt;
  logic             blink;
  logic             svc;

`ifdef PED_REQ_EN
  logic ped_lat;

  // A press on the very entry edge must survive the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ped_lat <= 1'b0;
    end else if (ped_req) begin
      ped_lat <= 1'b1;
    end else if (st_nx == LR_GREEN_S &&
                 st != LR_GREEN_S) begin
      ped_lat <= 1'b0;
    end
  end

  assign svc      = lr_has_car | ped_lat;
  assign ped_walk = (st == LR_GREEN_S);
`else
  logic unused_ped;

  assign unused_ped = ped_req;
  assign svc        = lr_has_car;
  assign ped_walk   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= HW_GREEN;
      cnt <= '0;
    end else begin
      st <= st_nx;
      if (st_nx != st) begin
        cnt <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Blink phase restarts at 1 every time FLASH is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink <= 1'b1;
      fcnt  <= '0;
    end else if (st != FLASH) begin
      blink <= 1'b1;
      fcnt  <= '0;
    end else if (fcnt == T_FLS) begin
      blink <= ~blink;
      fcnt  <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      HW_GREEN: begin
        if (cnt >= T_HWG && svc)
          st_nx = HW_YELLOW;
      end
      HW_YELLOW: begin
        if (cnt == T_YEL)
          st_nx = CLR_A;
      end
      CLR_A: begin
        if (cnt == T_CLR)
          st_nx = flash_mode ? FLASH : LR_GREEN_S;
      end
      LR_GREEN_S: begin
        if (cnt == T_LRG)
          st_nx = LR_YELLOW;
      end
      LR_YELLOW: begin
        if (cnt == T_YEL)
          st_nx = CLR_B;
      end
      CLR_B: begin
        if (cnt == T_CLR)
          st_nx = flash_mode ? FLASH : HW_GREEN;
      end
      FLASH: begin
        if (!flash_mode)
          st_nx = CLR_B;
      end
      ST_BAD: st_nx = CLR_B;
    endcase
  end

  always_comb begin
    hw_light = 3'b001;
    lr_light = 3'b001;
    unique case (st)
      HW_GREEN:   hw_light = 3'b100;
      HW_YELLOW:  hw_light = 3'b010;
      LR_GREEN_S: lr_light = 3'b100;
      LR_YELLOW:  lr_light = 3'b010;
      FLASH: begin
        hw_light = blink ? 3'b010 : 3'b000;
        lr_light = blink ? 3'b001 : 3'b000;
      end
      CLR_A, CLR_B, ST_BAD: ;
    endcase
  end

  assign state = st;

endmodule

// File: tb/tb_adaptive_traffic_controller.sv
// Directed bench for adaptive_traffic_controller: default instance
// plus an all-ones-parameter instance for the minimum-period case.
module tb_adaptive_traffic_controller;

  localparam logic [2:0] G = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b001;
  localparam logic [2:0] D = 3'b000;

  typedef struct {
    logic       rst;
    logic       car;
    logic       flash;
    logic       ped;
    int         cyc;
    logic [2:0] st;
    logic [2:0] hw;
    logic [2:0] lr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, car, flash, ped;
  logic [2:0] hw, lr, st;
  logic       walk;

  logic       rst1, car1, flash1, ped1;
  logic [2:0] hw1, lr1, st1;
  logic       walk1;

  int checks = 0;
  int fails  = 0;

  vec_t tbl[$];

  always #5 clk = ~clk;

  adaptive_traffic_controller dut (
    .clk(clk), .rst(rst), .lr_has_car(car),
    .flash_mode(flash), .ped_req(ped),
    .hw_light(hw), .lr_light(lr),
    .ped_walk(walk), .state(st)
  );

  adaptive_traffic_controller #(
    .HW_MIN_GREEN(1), .LR_GREEN(1), .YELLOW(1),
    .ALL_RED(1), .FLASH_HALF(1), .CNT_W(8)
  ) dut1 (
    .clk(clk), .rst(rst1), .lr_has_car(car1),
    .flash_mode(flash1), .ped_req(ped1),
    .hw_light(hw1), .lr_light(lr1),
    .ped_walk(walk1), .state(st1)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [2:0] act,
                     input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %b expected %b",
               nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic c,
                     input logic f, input int n,
                     input logic [2:0] s,
                     input logic [2:0] h,
                     input logic [2:0] l);
    vec_t v;
    v.rst = r; v.car = c; v.flash = f; v.ped = 1'b0;
    v.cyc = n; v.st = s; v.hw = h; v.lr = l;
    tbl.push_back(v);
  endtask

  function automatic logic [2:0] exp_walk(input logic [2:0] s);
`ifdef PED_REQ_EN
    return {2'b00, s == 3'd3};
`else
    return 3'b000 & {3{s[0]}};
`endif
  endfunction

  initial begin
    rst = 1'b1; car = 1'b0; flash = 1'b0; ped = 1'b0;
    rst1 = 1'b1; car1 = 1'b0; flash1 = 1'b0; ped1 = 1'b0;

    // reset and one full 192-cycle period
    add(1,0,0,  1, 0, G, R);
    add(0,1,0, 69, 0, G, R);
    add(0,1,0,  1, 1, Y, R);
    add(0,1,0, 24, 1, Y, R);
    add(0,1,0,  1, 2, R, R);
    add(0,1,0,  1, 3, R, G);
    add(0,1,0, 69, 3, R, G);
    add(0,1,0,  1, 4, R, Y);
    add(0,1,0, 24, 4, R, Y);
    add(0,1,0,  1, 5, R, R);
    add(0,1,0,  1, 0, G, R);
    // long idle, then demand; local green ignores demand
    add(0,0,0,500, 0, G, R);
    add(0,1,0,  1, 1, Y, R);
    add(0,0,0, 24, 1, Y, R);
    add(0,0,0,  1, 2, R, R);
    add(0,0,0,  1, 3, R, G);
    add(0,0,0, 70, 4, R, Y);
    add(0,0,0, 25, 5, R, R);
    add(0,0,0,  1, 0, G, R);
    // early single-cycle detector pulse is not honoured
    add(0,0,0, 30, 0, G, R);
    add(0,1,0,  1, 0, G, R);
    add(0,0,0,100, 0, G, R);
    // flash raised mid-yellow, entered after CLR_A
    add(0,1,0,  1, 1, Y, R);
    add(0,0,0, 10, 1, Y, R);
    add(0,0,1, 14, 1, Y, R);
    add(0,0,1,  1, 2, R, R);
    add(0,0,1,  1, 6, Y, R);
    add(0,0,1,  9, 6, Y, R);
    add(0,0,1,  1, 6, D, D);
    add(0,0,1,  9, 6, D, D);
    add(0,0,1,  1, 6, Y, R);
    add(0,0,0,  1, 5, R, R);
    add(0,0,0,  1, 0, G, R);
    // flash via CLR_B, and CLR_B re-check after FLASH exit
    add(0,1,0, 70, 1, Y, R);
    add(0,0,0, 25, 2, R, R);
    add(0,0,0,  1, 3, R, G);
    add(0,0,0, 70, 4, R, Y);
    add(0,0,1, 25, 5, R, R);
    add(0,0,1,  1, 6, Y, R);
    add(0,0,0,  1, 5, R, R);
    add(0,0,1,  1, 6, Y, R);
    add(0,0,0,  1, 5, R, R);
    add(0,0,0,  1, 0, G, R);
    // reset at LR_YELLOW cycle 12, with other inputs high
    add(0,1,0, 70, 1, Y, R);
    add(0,1,0, 25, 2, R, R);
    add(0,1,0,  1, 3, R, G);
    add(0,1,0, 70, 4, R, Y);
    add(0,1,0, 12, 4, R, Y);
    add(1,1,1,  1, 0, G, R);
    add(0,1,0, 69, 0, G, R);
    add(0,1,0,  1, 1, Y, R);
    // reset while in FLASH (dark phase)
    add(0,0,1, 25, 2, R, R);
    add(0,0,1,  1, 6, Y, R);
    add(0,0,1, 12, 6, D, D);
    add(1,0,1,  1, 0, G, R);
    add(0,0,0,100, 0, G, R);

    foreach (tbl[i]) begin
      rst   = tbl[i].rst;
      car   = tbl[i].car;
      flash = tbl[i].flash;
      ped   = tbl[i].ped;
      tick(tbl[i].cyc);
      chk("state", i, st, tbl[i].st);
      chk("hw_light", i, hw, tbl[i].hw);
      chk("lr_light", i, lr, tbl[i].lr);
      chk("ped_walk", i, {2'b00, walk},
          exp_walk(tbl[i].st));
    end

`ifdef PED_REQ_EN
    // pulse at cycle 5 serves the local phase
    rst = 1'b1; car = 1'b0; flash = 1'b0; ped = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(5);
    ped = 1'b1;
    tick(1);
    ped = 1'b0;
    tick(63);
    chk("ped_hwg", 0, st, 3'd0);
    tick(1);
    chk("ped_hwy", 0, st, 3'd1);
    tick(26);
    chk("ped_lrg", 0, st, 3'd3);
    for (int k = 0; k < 70; k++) begin
      chk("ped_walk_on", k, {2'b00, walk}, 3'b001);
      tick(1);
    end
    chk("ped_lry", 0, st, 3'd4);
    chk("ped_walk_off", 0, {2'b00, walk}, 3'b000);
    tick(26);
    chk("ped_back", 0, st, 3'd0);
    tick(200);
    chk("ped_clear", 0, st, 3'd0);
    // press coinciding with LR_GREEN_S entry stays latched
    car = 1'b1;
    tick(1);
    car = 1'b0;
    chk("ped_win_y", 0, st, 3'd1);
    tick(25);
    chk("ped_win_a", 0, st, 3'd2);
    ped = 1'b1;
    tick(1);
    ped = 1'b0;
    chk("ped_win_g", 0, st, 3'd3);
    tick(96);
    chk("ped_win_b", 0, st, 3'd0);
    tick(69);
    chk("ped_win_hold", 0, st, 3'd0);
    tick(1);
    chk("ped_win_srv", 0, st, 3'd1);
`else
    // button ignored without the latch
    car = 1'b0; ped = 1'b1;
    tick(200);
    ped = 1'b0;
    chk("ped_ignored", 0, st, 3'd0);
    chk("ped_walk0", 0, {2'b00, walk}, 3'b000);
`endif

    // all-ones parameters: every state lasts one cycle
    tick(1);
    chk("min_rst", 0, st1, 3'd0);
    rst1 = 1'b0; car1 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      chk("min_state", k, st1, 3'(k % 6));
    end
    chk("min_hw", 0, hw1, G);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
